mem_arbiter: RTL
================

MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter ADDR_W, 28, memory line address width.
REQ-002 Parameter DATA_W, 128, memory beat width.
REQ-003 Parameter BEATS, 4, read beats per refill; range 1-8.
REQ-004 Parameter STARVE_LIM, 4, consecutive dcache grants tolerated while icache waits; range 1-15.
REQ-005 Port clk  in  1  single clock; all state updates on posedge clk.
REQ-006 Port reset  in  1  asynchronous, active-high reset.
REQ-007 Ports ic_req_valid in 1, ic_req_ready out 1, ic_req_addr in ADDR_W: icache read request; icache never writes.
REQ-008 Ports ic_resp_valid out 1, ic_resp_data out DATA_W: icache refill beats.
REQ-009 Ports dc_req_valid in 1, dc_req_ready out 1, dc_req_rw in 1 (1=write), dc_req_addr in ADDR_W, dc_req_wdata in DATA_W, dc_req_wmask in DATA_W/8: dcache request.
REQ-010 Ports dc_resp_valid out 1, dc_resp_data out DATA_W: dcache refill beats.
REQ-011 Ports mem_req_valid out 1, mem_req_ready in 1, mem_req_rw out 1, mem_req_addr out ADDR_W: memory command channel.
REQ-012 Ports mem_wdata_valid out 1, mem_wdata_ready in 1, mem_wdata out DATA_W, mem_wmask out DATA_W/8: memory write data channel.
REQ-013 Ports mem_resp_valid in 1, mem_resp_data in DATA_W: memory read beats, no backpressure.
REQ-014 Port busy out 1: high in every state except IDLE.

Function
REQ-015 FSM SHALL have states IDLE, CMD, WDATA, RESP; exactly one transaction outstanding at any time.
REQ-016 IDLE: if any request valid, winner's req_ready SHALL be 1 combinationally that cycle; loser's req_ready 0; winner's rw/addr/wdata/wmask latched; next state CMD.
REQ-017 Priority: dcache wins when both valid, unless starve counter == STARVE_LIM, then icache wins.
REQ-018 Starve counter: +1 on each dcache grant with ic_req_valid high; cleared on icache grant or any grant with ic_req_valid low; saturates at STARVE_LIM.
REQ-019 CMD: mem_req_valid=1 with latched rw/addr, held stable until mem_req_ready; then write -> WDATA, read -> RESP.
REQ-020 WDATA: mem_wdata_valid=1 with latched data/mask, stable until mem_wdata_ready; then IDLE; writes produce no response.
REQ-021 RESP: each mem_resp_valid cycle SHALL forward mem_resp_data to owner's resp_data with owner resp_valid=1 in the same cycle (combinational, zero latency); non-owner resp_valid=0.
REQ-022 RESP: beat counter (width clog2(BEATS)+1) counts beats; on beat BEATS return to IDLE the following cycle.
REQ-023 mem_resp_valid outside RESP SHALL be dropped; both resp_valid 0.
REQ-024 Minimum read turnaround: grant cycle N, mem_req_valid at N+1; next grant no earlier than cycle after last beat.
REQ-025 req_ready SHALL be 0 for both requesters in CMD, WDATA, RESP.
REQ-026 Requester deasserting valid after grant has no effect; transaction completes.

Reset
REQ-027 Reset asserted: state=IDLE, beat counter=0, starve counter=0, latched owner=dcache, latched fields=0, immediately and asynchronously.
REQ-028 During reset all valid/ready outputs and busy SHALL be 0; data outputs 0.
REQ-029 Reset mid-transaction abandons it; beats arriving after deassertion are dropped per REQ-023.

Structure
REQ-030 FSM state encodings and BEATS/DATA_W defaults SHALL live in const.vh.
REQ-031 Priority/starvation selection SHALL be one sub-module, mem_arb_select (inputs: both valids, starve count; outputs: grant_ic, grant_dc).

Verification
REQ-032 dc read only, addr 0x0000010, mem_req_ready at N+3, four beats 0xA..0xD -> dc_resp_valid 4 cycles with data 0xA..0xD, ic_resp_valid 0, busy low after last beat.
REQ-033 Both valid continuously, dcache always reads, STARVE_LIM=4 -> grant order D,D,D,D,I,D,D,D,D,I.
REQ-034 dc write addr 0x0000020, wdata 0x1234, wmask 0xFFFF, mem_wdata_ready delayed 5 cycles -> mem_wdata/mask stable throughout, no resp, IDLE after accept.
REQ-035 Reset pulsed during RESP after beat 2 -> outputs zero immediately; remaining beats 3,4 produce no resp_valid; next ic request serviced normally.
REQ-036 mem_resp_valid pulsed while IDLE -> no resp_valid on either side, state stays IDLE.
REQ-037 ic_req_valid dropped one cycle after grant -> command still issued, all four beats delivered to icache.

Source files
------------

// File: rtl/mem_arbiter_pkg.sv
// Shared constants for the icache/dcache memory arbiter: FSM encodings,
// default geometry and the starvation counter update rule.
package mem_arbiter_pkg;

  localparam int DEF_ADDR_W     = 28;
  localparam int DEF_DATA_W     = 128;
  localparam int DEF_BEATS      = 4;
  localparam int DEF_STARVE_LIM = 4;

  // Wide enough for the largest legal starvation limit (15).
  localparam int STARVE_W = 4;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_CMD   = 2'd1;
  localparam logic [1:0] ST_WDATA = 2'd2;
  localparam logic [1:0] ST_RESP  = 2'd3;

  localparam logic OWNER_DC = 1'b0;
  localparam logic OWNER_IC = 1'b1;

  // Count dcache wins that left the icache waiting; anything else clears it.
  function automatic logic [STARVE_W-1:0] starve_next(
    input logic [STARVE_W-1:0] cnt,
    input logic [STARVE_W-1:0] lim,
    input logic                dc_won,
    input logic                ic_waiting
  );
    if (dc_won && ic_waiting) begin
      return (cnt >= lim) ? lim : cnt + 1'b1;
    end
    return '0;
  endfunction

endpackage

// File: rtl/mem_arb_select.sv
// Requester selection: dcache has priority unless the icache has been
// passed over STARVE_LIM times in a row.
module mem_arb_select
  import mem_arbiter_pkg::*;
#(
  parameter int STARVE_LIM = DEF_STARVE_LIM
) (
  input  logic                ic_valid,
  input  logic                dc_valid,
  input  logic [STARVE_W-1:0] starve_cnt,
  output logic                grant_ic,
  output logic                grant_dc
);

  logic starved;

  always_comb begin
    starved  = (starve_cnt == STARVE_W'(STARVE_LIM));
    grant_ic = ic_valid && (!dc_valid || starved);
    grant_dc = dc_valid && !grant_ic;
  end

endmodule

// File: rtl/mem_arbiter.sv
// Two-requester memory arbiter: one outstanding transaction, command then
// either a write-data beat or BEATS read beats forwarded to the owner.
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int ADDR_W     = DEF_ADDR_W,
  parameter int DATA_W     = DEF_DATA_W,
  parameter int BEATS      = DEF_BEATS,
  parameter int STARVE_LIM = DEF_STARVE_LIM
) (
  input  logic                clk,
  input  logic                reset,

  input  logic                ic_req_valid,
  output logic                ic_req_ready,
  input  logic [ADDR_W-1:0]   ic_req_addr,
  output logic                ic_resp_valid,
  output logic [DATA_W-1:0]   ic_resp_data,

  input  logic                dc_req_valid,
  output logic                dc_req_ready,
  input  logic                dc_req_rw,
  input  logic [ADDR_W-1:0]   dc_req_addr,
  input  logic [DATA_W-1:0]   dc_req_wdata,
  input  logic [DATA_W/8-1:0] dc_req_wmask,
  output logic                dc_resp_valid,
  output logic [DATA_W-1:0]   dc_resp_data,

  output logic                mem_req_valid,
  input  logic                mem_req_ready,
  output logic                mem_req_rw,
  output logic [ADDR_W-1:0]   mem_req_addr,
  output logic                mem_wdata_valid,
  input  logic                mem_wdata_ready,
  output logic [DATA_W-1:0]   mem_wdata,
  output logic [DATA_W/8-1:0] mem_wmask,
  input  logic                mem_resp_valid,
  input  logic [DATA_W-1:0]   mem_resp_data,

  output logic                busy
);

  localparam int MASK_W = DATA_W / 8;
  localparam int BCNT_W = $clog2(BEATS) + 1;

  logic [1:0]          state;
  logic [BCNT_W-1:0]   beat_cnt;
  logic [STARVE_W-1:0] starve_cnt;
  logic                owner;
  logic                lat_rw;
  logic [ADDR_W-1:0]   lat_addr;
  logic [DATA_W-1:0]   lat_wdata;
  logic [MASK_W-1:0]   lat_wmask;

  logic grant_ic;
  logic grant_dc;
  logic idle;
  logic beat;
  logic last_beat;

  mem_arb_select #(
    .STARVE_LIM (STARVE_LIM)
  ) u_select (
    .ic_valid   (ic_req_valid),
    .dc_valid   (dc_req_valid),
    .starve_cnt (starve_cnt),
    .grant_ic   (grant_ic),
    .grant_dc   (grant_dc)
  );

  // Ready is combinational on the request valids, so it alone needs an
  // explicit reset gate; every other output follows the cleared state.
  always_comb begin
    idle            = (state == ST_IDLE);
    beat            = (state == ST_RESP) && mem_resp_valid;
    last_beat       = (beat_cnt == BCNT_W'(BEATS - 1));

    ic_req_ready    = idle && grant_ic && !reset;
    dc_req_ready    = idle && grant_dc && !reset;
    busy            = !idle;

    mem_req_valid   = (state == ST_CMD);
    mem_req_rw      = lat_rw;
    mem_req_addr    = lat_addr;
    mem_wdata_valid = (state == ST_WDATA);
    mem_wdata       = lat_wdata;
    mem_wmask       = lat_wmask;

    ic_resp_valid   = beat && (owner == OWNER_IC);
    dc_resp_valid   = beat && (owner == OWNER_DC);
    ic_resp_data    = ic_resp_valid ? mem_resp_data : '0;
    dc_resp_data    = dc_resp_valid ? mem_resp_data : '0;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= ST_IDLE;
      beat_cnt   <= '0;
      starve_cnt <= '0;
      owner      <= OWNER_DC;
      lat_rw     <= 1'b0;
      lat_addr   <= '0;
      lat_wdata  <= '0;
      lat_wmask  <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (grant_ic || grant_dc) begin
            owner      <= grant_ic ? OWNER_IC : OWNER_DC;
            lat_rw     <= grant_dc ? dc_req_rw : 1'b0;
            lat_addr   <= grant_ic ? ic_req_addr : dc_req_addr;
            lat_wdata  <= grant_dc ? dc_req_wdata : '0;
            lat_wmask  <= grant_dc ? dc_req_wmask : '0;
            beat_cnt   <= '0;
            starve_cnt <= starve_next(starve_cnt, STARVE_W'(STARVE_LIM),
                                      grant_dc, ic_req_valid);
            state      <= ST_CMD;
          end
        end
        ST_CMD: begin
          if (mem_req_ready) begin
            state <= lat_rw ? ST_WDATA : ST_RESP;
          end
        end
        ST_WDATA: begin
          if (mem_wdata_ready) begin
            state <= ST_IDLE;
          end
        end
        ST_RESP: begin
          if (mem_resp_valid) begin
            if (last_beat) begin
              beat_cnt <= '0;
              state    <= ST_IDLE;
            end else begin
              beat_cnt <= beat_cnt + 1'b1;
            end
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule
